inst_rom_loader: RTL and testbench
==================================

// Module: inst_rom_loader
// PURPOSE
//  Instruction-memory responder on the fetch side of the core's ROM interface (rom_ce/rom_addr/rom_data).
//  Serves 32-bit instruction words to the pipeline with zero-cycle (combinational) read so if_id latches them with the PC.
//  Contents are written through a byte-serial load port with valid/ready handshake, driven by a host/testbench loader FSM.
// PARAMETERS
//  AW      10   word-address width; DEPTH = 2**AW words; byte address bits [AW+1:2] select the word
// PORTS
//  clk          in   1   system clock, all state updates on rising edge
//  rst          in   1   reset, synchronous, active-high
//  rom_ce_i     in   1   fetch enable from pc_reg
//  rom_addr_i   in   32  fetch byte address (PC)
//  rom_data_o   out  32  instruction word, combinational from rom_ce_i/rom_addr_i/state
//  ld_start     in   1   pulse: begin (or restart) a program load at word 0
//  ld_valid     in   1   ld_byte valid
//  ld_byte      in   8   program byte, big-endian within each word
//  ld_last      in   1   qualifies the accepted byte as the final byte of the image
//  ld_ready     out  1   loader accepts a byte this cycle
//  ld_done      out  1   one-cycle pulse: load complete
//  ld_err       out  1   sticky: image exceeded DEPTH words; cleared by ld_start or rst
//  busy         out  1   load in progress (state != IDLE)
//  rom_err_o    out  1   only when ROM_ADDR_CHECK_EN defined; see CONFIGURATION
// BEHAVIOUR
//  - Reset: state=IDLE; ld_ready=0, ld_done=0, ld_err=0, busy=0; word ptr=0, byte cnt=0, shift reg=0.
//    Memory array NOT cleared by reset. Reset mid-load aborts: partial word discarded, words already written kept.
//  - Fetch: rom_data_o = mem[rom_addr_i[AW+1:2]] when rom_ce_i=1 and busy=0; else 32'h0 (NOP). No latency.
//  - FSM states IDLE, LOAD, DONE:
//    IDLE: ld_ready=0; ld_start -> LOAD, ptr=0, cnt=0, ld_err=0. ld_valid ignored.
//    LOAD: ld_ready=1 (0 once ld_err set, see overflow). Byte accepted on ld_valid&ld_ready;
//      cnt 0..3 places byte at [31:24],[23:16],[15:8],[7:0]. On 4th byte: mem[ptr]<=word, ptr+1, cnt=0.
//      ld_last on accepted byte: write word (unfilled low bytes zero-padded) if cnt>0 or byte completes it -> DONE.
//      ld_last with accepted byte always ends load, even on exact word boundary (no extra empty word).
//      ld_start in LOAD: restart at ptr=0, cnt=0, partial word dropped, ld_err cleared; same-cycle byte dropped.
//    DONE: ld_done=1 for exactly one cycle, ld_ready=0, busy=1; -> IDLE next cycle. ld_start here ignored.
//  - Overflow: a word write with ptr=DEPTH is suppressed, ld_err<=1, ld_ready<=0 next cycle; FSM stays
//    LOAD until ld_start or rst (ld_last not acceptable since ready=0). ptr never wraps.
//  - Write and fetch same word same cycle: fetch returns old content (busy=1 anyway forces 0).
//  - ld_done and ld_err never asserted in the same cycle as rst.
// CONFIGURATION
//  ROM_ADDR_CHECK_EN defined: rom_err_o = rom_ce_i & !busy & (rom_addr_i[1:0]!=0 | rom_addr_i[31:AW+2]!=0);
//    when rom_err_o=1, rom_data_o=32'h0. Combinational, no state.
//  Not defined: rom_err_o port absent; addr[1:0] and addr[31:AW+2] ignored (fetch aliases modulo DEPTH).
// TESTING
//  T1 rst held 2 cycles -> ld_ready=0, ld_done=0, ld_err=0, busy=0; rom_ce_i=0 -> rom_data_o=0.
//  T2 ld_start; bytes 34 01 00 10, 3c 02 ab cd (last on cd) -> ld_done pulse 1 cycle after cd;
//     fetch addr 0 -> 32'h34010010, addr 4 -> 32'h3c02abcd, same cycle as address, busy=0.
//  T3 load 5 bytes 11 22 33 44 55(last) -> word1 = 32'h55000000; mid-load fetch (ce=1) returns 0.
//  T4 ld_valid toggled randomly during T2 image -> identical contents; bytes with ld_valid=0 ignored.
//  T5 AW=2: 5 full words -> ld_err=1 at 5th word, ld_ready=0, mem[0..3] intact; ld_start clears ld_err.
//  T6 rst after 6 bytes of new image -> word0 updated, word1 old value; with ROM_ADDR_CHECK_EN fetch
//     addr 32'h2 -> rom_err_o=1, rom_data_o=0; addr 32'h1000 (AW=10) -> rom_err_o=1.

Source files
------------

// File: rtl/inst_rom_loader.sv
// inst_rom_loader: combinational-read instruction ROM filled through a byte-serial valid/ready load port.
// Optional ROM_ADDR_CHECK_EN adds rom_err_o for misaligned or out-of-range fetch addresses.
module inst_rom_loader #(
    parameter int AW = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rom_ce_i,
    input  logic [31:0] rom_addr_i,
    output logic [31:0] rom_data_o,
    input  logic        ld_start,
    input  logic        ld_valid,
    input  logic [7:0]  ld_byte,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        ld_done,
    output logic        ld_err,
    output logic        busy
`ifdef ROM_ADDR_CHECK_EN
    ,
    output logic        rom_err_o
`endif
);
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t      r_state;
    logic        r_ready;
    logic        r_err;
    logic [AW:0] r_ptr;
    logic [1:0]  r_cnt;
    logic [31:0] r_shift;
    logic [31:0] r_mem [DEPTH];

    logic        w_acc;
    logic        w_wr;
    logic        w_ovf;
    logic        w_addr_bad;
    logic [31:0] w_word;

    // big-endian placement: byte n of a word lands at bits [31-8n -: 8]
    assign w_word = r_shift | ({24'b0, ld_byte} << {~r_cnt, 3'b000});
    assign w_acc  = (r_state == LOAD) && ld_valid && r_ready && !ld_start;
    assign w_wr   = w_acc && (r_cnt == 2'd3 || ld_last);
    assign w_ovf  = w_wr && r_ptr[AW];

    assign busy     = (r_state != IDLE);
    assign ld_ready = r_ready;
    assign ld_done  = (r_state == DONE) && !rst;
    assign ld_err   = r_err && !rst;

`ifdef ROM_ADDR_CHECK_EN
    assign w_addr_bad = (rom_addr_i[1:0] != 2'b00) || (rom_addr_i[31:AW+2] != '0);
    assign rom_err_o  = rom_ce_i && !busy && w_addr_bad;
`else
    logic w_unused_addr;
    assign w_addr_bad    = 1'b0;
    assign w_unused_addr = ^{rom_addr_i[31:AW+2], rom_addr_i[1:0]};
`endif

    assign rom_data_o = (rom_ce_i && !busy && !w_addr_bad) ? r_mem[rom_addr_i[AW+1:2]] : 32'h0;

    // array deliberately has no reset so a reset keeps already-loaded words
    always_ff @(posedge clk) begin
        if (w_wr && !r_ptr[AW]) r_mem[r_ptr[AW-1:0]] <= w_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (r_state == DONE) begin
            r_state <= IDLE;
        end else if (ld_start) begin
            r_state <= LOAD;
            r_ready <= 1'b1;
            r_err   <= 1'b0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (w_wr) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_ptr   <= w_ovf ? r_ptr : r_ptr + 1'b1;
            r_err   <= r_err || w_ovf;
            r_ready <= !(w_ovf || ld_last);
            r_state <= (ld_last && !w_ovf) ? DONE : LOAD;
        end else if (w_acc) begin
            r_cnt   <= r_cnt + 1'b1;
            r_shift <= w_word;
        end
    end
endmodule

// File: tb/tb_inst_rom_loader.sv
// tb_inst_rom_loader: directed load/fetch scenarios with a queue-based scoreboard checked on the falling edge.
module tb_inst_rom_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rom_ce_i = 1'b0;
    logic [31:0] rom_addr_i = '0;
    logic [31:0] rom_data_o;
    logic        ld_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_byte = '0;
    logic        ld_last = 1'b0;
    logic        ld_ready;
    logic        ld_done;
    logic        ld_err;
    logic        busy;
    logic        rom_err;

    inst_rom_loader #(.AW(2)) dut (
        .clk(clk), .rst(rst), .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i), .rom_data_o(rom_data_o),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
        .ld_ready(ld_ready), .ld_done(ld_done), .ld_err(ld_err), .busy(busy)
`ifdef ROM_ADDR_CHECK_EN
        , .rom_err_o(rom_err)
`endif
    );
`ifndef ROM_ADDR_CHECK_EN
    assign rom_err = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t       sb_q[$];
    int         done_q[$];
    logic [7:0] img[$];
    int         checks = 0;
    int         errors = 0;
    exp_t       e;
    logic [31:0] act;

    localparam int DATA = 0, READY = 1, DONE_S = 2, ERR = 3, BUSY = 4, RERR = 5;

    function automatic logic [31:0] pick(input int s);
        case (s)
            DATA:    return rom_data_o;
            READY:   return {31'b0, ld_ready};
            DONE_S:  return {31'b0, ld_done};
            ERR:     return {31'b0, ld_err};
            BUSY:    return {31'b0, busy};
            default: return {31'b0, rom_err};
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            act = pick(e.sel);
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.val);
            end
        end
        if (ld_done === 1'b1) begin
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got ld_done=1 expected 0 at %0t", $time);
            end else begin
                void'(done_q.pop_front());
            end
        end
    end

    task automatic expect_sig(input string n, input int s, input logic [31:0] v);
        sb_q.push_back('{n, s, v});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input int gaps);
        bit ok;
        int n;
        for (int i = 0; i < gaps; i++) begin
            ld_valid = 1'b0;
            ld_byte  = 8'($urandom);
            ld_last  = 1'($urandom);
            tick();
        end
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 20) begin
            @(negedge clk);
            ok = ld_ready;
            tick();
            n++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL byte_accept_timeout: got ld_ready=0 expected 1 for byte %h", b);
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] d, input string n);
        rom_ce_i   = 1'b1;
        rom_addr_i = a;
        expect_sig(n, DATA, d);
        tick();
        rom_ce_i = 1'b0;
    endtask

    task automatic done_chk(input string n);
        expect_sig({n, "_done"}, DONE_S, 1);
        expect_sig({n, "_busy_done"}, BUSY, 1);
        expect_sig({n, "_ready_done"}, READY, 0);
        tick();
        expect_sig({n, "_done_low"}, DONE_S, 0);
        expect_sig({n, "_idle"}, BUSY, 0);
        tick();
    endtask

    task automatic load_img(input int gmax, input string n);
        pulse_start();
        for (int i = 0; i < img.size(); i++) begin
            if (i == img.size() - 1) done_q.push_back(1);
            send_byte(img[i], i == img.size() - 1, $urandom_range(gmax, 0));
        end
        done_chk(n);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // T1 reset
        tick();
        tick();
        expect_sig("rst_ready", READY, 0);
        expect_sig("rst_done", DONE_S, 0);
        expect_sig("rst_err", ERR, 0);
        expect_sig("rst_busy", BUSY, 0);
        expect_sig("rst_data", DATA, 0);
        rst = 1'b0;
        tick();
        expect_sig("post_rst_busy", BUSY, 0);
        tick();

        // T2 two-word image
        img = '{8'h34, 8'h01, 8'h00, 8'h10, 8'h3c, 8'h02, 8'hab, 8'hcd};
        pulse_start();
        expect_sig("t2_ready", READY, 1);
        expect_sig("t2_busy", BUSY, 1);
        for (int i = 0; i < img.size(); i++) begin
            if (i == img.size() - 1) done_q.push_back(1);
            send_byte(img[i], i == img.size() - 1, 0);
        end
        rom_ce_i = 1'b1;
        rom_addr_i = 32'h0;
        expect_sig("t2_fetch_in_done", DATA, 0);
        done_chk("t2");
        fetch(32'h0, 32'h34010010, "t2_w0");
        fetch(32'h4, 32'h3c02abcd, "t2_w1");
`ifdef ROM_ADDR_CHECK_EN
        rom_ce_i = 1'b1;
        rom_addr_i = 32'h10;
        expect_sig("t2_oor_err", RERR, 1);
        expect_sig("t2_oor_data", DATA, 0);
        tick();
        rom_ce_i = 1'b0;
`else
        fetch(32'h10, 32'h34010010, "t2_alias_w0");
        fetch(32'h7, 32'h3c02abcd, "t2_lowbits_ignored");
`endif

        // IDLE ignores the load port
        ld_valid = 1'b1;
        ld_byte  = 8'hff;
        ld_last  = 1'b1;
        tick();
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        expect_sig("idle_busy", BUSY, 0);
        expect_sig("idle_ready", READY, 0);
        tick();
        fetch(32'h0, 32'h34010010, "idle_w0_kept");

        // T3 partial final word, mid-load fetch returns NOP
        pulse_start();
        send_byte(8'h11, 1'b0, 0);
        send_byte(8'h22, 1'b0, 0);
        rom_ce_i = 1'b1;
        rom_addr_i = 32'h0;
        expect_sig("t3_midload_fetch", DATA, 0);
        expect_sig("t3_midload_busy", BUSY, 1);
        tick();
        rom_ce_i = 1'b0;
        send_byte(8'h33, 1'b0, 0);
        send_byte(8'h44, 1'b0, 0);
        done_q.push_back(1);
        send_byte(8'h55, 1'b1, 0);
        done_chk("t3");
        fetch(32'h0, 32'h11223344, "t3_w0");
        fetch(32'h4, 32'h55000000, "t3_w1_padded");

        // last on exact word boundary; ld_start during DONE ignored
        pulse_start();
        send_byte(8'haa, 1'b0, 0);
        send_byte(8'hbb, 1'b0, 0);
        send_byte(8'hcc, 1'b0, 0);
        done_q.push_back(1);
        send_byte(8'hdd, 1'b1, 0);
        expect_sig("t3b_done", DONE_S, 1);
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        expect_sig("t3b_start_in_done_busy", BUSY, 0);
        expect_sig("t3b_start_in_done_ready", READY, 0);
        tick();
        fetch(32'h0, 32'haabbccdd, "t3b_w0");
        fetch(32'h4, 32'h55000000, "t3b_no_extra_word");

        // T4 T2 image with random valid gaps
        img = '{8'h34, 8'h01, 8'h00, 8'h10, 8'h3c, 8'h02, 8'hab, 8'hcd};
        load_img(3, "t4");
        fetch(32'h0, 32'h34010010, "t4_w0");
        fetch(32'h4, 32'h3c02abcd, "t4_w1");

        // T5 overflow at DEPTH=4
        pulse_start();
        for (int w = 0; w < 5; w++)
            for (int j = 0; j < 4; j++)
                send_byte(8'ha0 + 8'(j * 16) + 8'(w), 1'b0, 0);
        expect_sig("t5_err", ERR, 1);
        expect_sig("t5_ready", READY, 0);
        expect_sig("t5_busy", BUSY, 1);
        tick();
        ld_valid = 1'b1;
        ld_last  = 1'b1;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        expect_sig("t5_err_sticky", ERR, 1);
        expect_sig("t5_still_load", BUSY, 1);
        tick();
        pulse_start();
        expect_sig("t5_start_clears_err", ERR, 0);
        expect_sig("t5_start_ready", READY, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_sig("t5_rst_idle", BUSY, 0);
        tick();
        fetch(32'h0, 32'ha0b0c0d0, "t5_w0");
        fetch(32'h4, 32'ha1b1c1d1, "t5_w1");
        fetch(32'h8, 32'ha2b2c2d2, "t5_w2");
        fetch(32'hc, 32'ha3b3c3d3, "t5_w3");

        // T6 reset mid-load keeps completed word only
        pulse_start();
        for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_sig("t6_rst_busy", BUSY, 0);
        expect_sig("t6_rst_ready", READY, 0);
        tick();
        fetch(32'h0, 32'h01020304, "t6_w0");
        fetch(32'h4, 32'ha1b1c1d1, "t6_w1_old");
`ifdef ROM_ADDR_CHECK_EN
        rom_ce_i = 1'b1;
        rom_addr_i = 32'h2;
        expect_sig("t6_misalign_err", RERR, 1);
        expect_sig("t6_misalign_data", DATA, 0);
        tick();
        rom_addr_i = 32'h0;
        expect_sig("t6_ok_err", RERR, 0);
        expect_sig("t6_ok_data", DATA, 32'h01020304);
        tick();
        rom_ce_i = 1'b0;
        expect_sig("t6_ce_off_err", RERR, 0);
        tick();
`endif

        // restart in LOAD drops partial word and same-cycle byte
        pulse_start();
        for (int i = 1; i <= 6; i++) send_byte(8'h11 * 8'(i), 1'b0, 0);
        ld_start = 1'b1;
        ld_valid = 1'b1;
        ld_byte  = 8'h77;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b0;
        expect_sig("t7_restart_ready", READY, 1);
        expect_sig("t7_restart_busy", BUSY, 1);
        send_byte(8'h88, 1'b0, 0);
        done_q.push_back(1);
        send_byte(8'h99, 1'b1, 0);
        done_chk("t7");
        fetch(32'h0, 32'h88990000, "t7_w0");
        fetch(32'h4, 32'ha1b1c1d1, "t7_w1_old");

        tick();
        tick();
        checks++;
        if (done_q.size() != 0) begin
            errors++;
            $display("FAIL missing_done: got %0d pending expected 0", done_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
